// File: rtl/led_display_scan_ctrl.sv
// Scan scheduler for a HUB75-style LED panel: requests row/plane shifts from the phy
// and drives blank, latch and BCM-weighted output-enable windows, overlapping shift with display.
module led_display_scan_ctrl #(
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  parameter int BIT_DEPTH      = 4,
  parameter int BASE_ON_CYCLES = 16,
  parameter int BLANK_CYCLES   = 2
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  enable_in,
  output logic                                  shift_req_out,
  output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]   shift_row_out,
  output logic [$clog2(BIT_DEPTH)-1:0]          shift_plane_out,
  input  logic                                  shift_ack_in,
  input  logic                                  shift_done_in,
  output logic                                  latch_out,
  output logic                                  oe_n_out,
  output logic [$clog2(NUM_ROW_PIXELS/2)-1:0]   row_addr_out,
  output logic                                  frame_done_out,
  output logic                                  busy_out
);

  localparam int R      = NUM_ROW_PIXELS / 2;
  localparam int RW     = $clog2(R);
  localparam int PW     = $clog2(BIT_DEPTH);
  localparam int MAX_ON = BASE_ON_CYCLES << (BIT_DEPTH - 1);
  localparam int CW_ON  = $clog2(MAX_ON + 1);
  localparam int CW_BL  = $clog2(BLANK_CYCLES + 1);
  localparam int CW     = (CW_ON > CW_BL) ? CW_ON : CW_BL;

  localparam logic [RW-1:0] LAST_ROW   = RW'(R - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(BIT_DEPTH - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

  if (BLANK_CYCLES < 1 || NUM_COL_PIXELS < 1) begin : g_bad_param
    $error("led_display_scan_ctrl: BLANK_CYCLES and NUM_COL_PIXELS must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_BLANK, S_LATCH, S_DISPLAY, S_WAIT
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pending;      // a request was accepted and its shift has not finished
  logic          done_flag;
  logic          stop;
  logic [PW-1:0] disp_plane;
  logic          done_v, handshake;
  logic          issue_first, issue_next, clear_done, set_stop, frame_done_next;
  logic          plane_wrap;
  logic [RW-1:0] next_row;
  logic [PW-1:0] next_plane;

  function automatic logic [CW-1:0] on_time(input logic [PW-1:0] plane);
    return CW'(BASE_ON_CYCLES) << plane;
  endfunction

  // Handshake: shift_req_out rises with a stable row/plane and holds until a cycle
  // where shift_ack_in is also high; it drops the next cycle. shift_done_in only
  // counts while an accepted request is outstanding, otherwise it is ignored.
  assign handshake = shift_req_out & shift_ack_in;
  assign done_v    = shift_done_in & pending;

  assign plane_wrap = (shift_plane_out == LAST_PLANE);
  assign next_plane = plane_wrap ? '0 : shift_plane_out + 1'b1;
  assign next_row   = !plane_wrap ? shift_row_out :
                      ((shift_row_out == LAST_ROW) ? '0 : shift_row_out + 1'b1);

  always_comb begin
    state_next      = state;
    cnt_next        = (cnt != '0) ? cnt - 1'b1 : cnt;
    issue_first     = 1'b0;
    issue_next      = 1'b0;
    clear_done      = 1'b0;
    set_stop        = 1'b0;
    frame_done_next = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable_in) begin
          issue_first = 1'b1;
          state_next  = S_FILL;
        end
      end
      S_FILL: begin
        if (done_v) begin
          state_next = S_BLANK;
          cnt_next   = BLANK_LOAD;
        end
      end
      S_BLANK: begin
        if (cnt == '0) state_next = S_LATCH;
      end
      S_LATCH: begin
        cnt_next   = on_time(shift_plane_out) - 1'b1;
        state_next = S_DISPLAY;
        if (enable_in) begin
          issue_next = 1'b1;
          clear_done = 1'b1;
        end else begin
          set_stop = 1'b1;
        end
        // Outputs are registered, so the pulse is scheduled one cycle ahead.
        frame_done_next = (on_time(shift_plane_out) == CW'(1)) &&
                          (shift_row_out == LAST_ROW) && plane_wrap;
      end
      S_DISPLAY: begin
        frame_done_next = (cnt == CW'(1)) && (row_addr_out == LAST_ROW) &&
                          (disp_plane == LAST_PLANE);
        if (cnt == '0) begin
          if (stop) begin
            state_next = S_IDLE;
          end else if (done_flag || done_v) begin
            state_next = S_BLANK;
            cnt_next   = BLANK_LOAD;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (done_v) begin
          state_next = S_BLANK;
          cnt_next   = BLANK_LOAD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state           <= S_IDLE;
      cnt             <= '0;
      pending         <= 1'b0;
      done_flag       <= 1'b0;
      stop            <= 1'b0;
      disp_plane      <= '0;
      shift_req_out   <= 1'b0;
      shift_row_out   <= '0;
      shift_plane_out <= '0;
      latch_out       <= 1'b0;
      oe_n_out        <= 1'b1;
      row_addr_out    <= '0;
      frame_done_out  <= 1'b0;
      busy_out        <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;

      if (handshake) begin
        shift_req_out <= 1'b0;
        pending       <= 1'b1;
      end else if (done_v) begin
        pending <= 1'b0;
      end

      if (issue_first) begin
        shift_req_out   <= 1'b1;
        shift_row_out   <= '0;
        shift_plane_out <= '0;
      end else if (issue_next) begin
        shift_req_out   <= 1'b1;
        shift_row_out   <= next_row;
        shift_plane_out <= next_plane;
      end

      if (state == S_IDLE || clear_done) begin
        done_flag <= 1'b0;
      end else if (done_v && (state == S_DISPLAY || state == S_WAIT)) begin
        done_flag <= 1'b1;
      end

      if (state == S_IDLE) begin
        stop <= 1'b0;
      end else if (set_stop) begin
        stop <= 1'b1;
      end

      if (state == S_LATCH) begin
        row_addr_out <= shift_row_out;
        disp_plane   <= shift_plane_out;
      end

      latch_out      <= (state_next == S_LATCH);
      oe_n_out       <= (state_next != S_DISPLAY);
      busy_out       <= (state_next != S_IDLE);
      frame_done_out <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_led_display_scan_ctrl.sv
// Bench for led_display_scan_ctrl: randomized phy delays, a slot-timeline model built from
// the scan rules, and a per-cycle comparison of every output against that timeline.
module tb_led_display_scan_ctrl;

  localparam int ROWS = 32;
  localparam int COLS = 64;
  localparam int BD   = 4;
  localparam int BASE = 16;
  localparam int BC   = 2;
  localparam int R    = ROWS / 2;
  localparam int RW   = $clog2(R);
  localparam int PW   = $clog2(BD);
  localparam int N    = 40000;
  localparam int NK   = 256;
  localparam int BIG  = 1 << 30;

  // clock / reset
  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic enable_in = 1'b1;
  logic shift_ack_in = 1'b0;
  logic shift_done_in = 1'b0;
  logic shift_req_out, latch_out, oe_n_out, frame_done_out, busy_out;
  logic [RW-1:0] shift_row_out, row_addr_out;
  logic [PW-1:0] shift_plane_out;

  always #5 clk = ~clk;

  led_display_scan_ctrl #(
    .NUM_ROW_PIXELS(ROWS), .NUM_COL_PIXELS(COLS), .BIT_DEPTH(BD),
    .BASE_ON_CYCLES(BASE), .BLANK_CYCLES(BC)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
    .shift_req_out(shift_req_out), .shift_row_out(shift_row_out),
    .shift_plane_out(shift_plane_out), .shift_ack_in(shift_ack_in),
    .shift_done_in(shift_done_in), .latch_out(latch_out), .oe_n_out(oe_n_out),
    .row_addr_out(row_addr_out), .frame_done_out(frame_done_out), .busy_out(busy_out)
  );

  // expected timeline, one entry per cycle
  logic          e_req[N], e_latch[N], e_oe[N], e_fd[N], e_busy[N];
  logic [RW-1:0] e_row[N], e_addr[N];
  logic [PW-1:0] e_plane[N];
  int ackd[NK], doned[NK], lat_c[NK];

  int n_checks = 0, n_errors = 0, cyc = 0;
  int t_a, dis_c, t_b, rst_c, t_fin, fd_seen = 0;
  int te, ns, n_a;
  bit ph_pending = 1'b0;
  int ph_done_at = 0, ph_req_since = -1, ph_k = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int c0);
    for (int c = c0; c < N; c++) begin
      e_req[c] = 1'b0; e_latch[c] = 1'b0; e_oe[c] = 1'b1; e_fd[c] = 1'b0; e_busy[c] = 1'b0;
    end
  endtask

  // Slot-level model: latch = max(done, end of previous display) + BLANK + 1,
  // display follows for BASE<<plane cycles, next request rises right after the latch.
  task automatic plan_run(input int t_en, input int kbase, input int max_slots,
                          input int dis, input int rst, output int t_end, output int n_slots);
    int row, plane, k, req_r, prev_end, ack_c, done_c, bstart, l, on;
    row = 0; plane = 0; k = kbase; req_r = t_en + 1; prev_end = -1;
    n_slots = 0; t_end = t_en + 1;
    while (1) begin
      ack_c  = req_r + 1 + ackd[k];
      done_c = ack_c + doned[k];
      for (int c = req_r; c <= ack_c; c++) begin
        e_req[c] = 1'b1; e_row[c] = RW'(row); e_plane[c] = PW'(plane);
      end
      bstart = (done_c > prev_end) ? done_c + 1 : prev_end + 1;
      l = bstart + BC;
      lat_c[k] = l;
      e_latch[l] = 1'b1;
      on = BASE << plane;
      for (int c = l + 1; c <= l + on; c++) e_oe[c] = 1'b0;
      for (int c = l + 1; c < N; c++) e_addr[c] = RW'(row);
      if (row == R - 1 && plane == BD - 1) e_fd[l + on] = 1'b1;
      t_end = l + on + 1;
      n_slots++;
      if (l >= dis || l >= rst || n_slots >= max_slots) break;
      req_r = l + 1; prev_end = l + on; k++;
      plane++;
      if (plane == BD) begin
        plane = 0; row = (row + 1) % R;
      end
    end
    for (int c = t_en + 1; c < t_end; c++) e_busy[c] = 1'b1;
    if (rst < N) begin
      for (int c = rst + 1; c < N; c++) begin
        e_req[c] = 1'b0; e_latch[c] = 1'b0; e_oe[c] = 1'b1; e_fd[c] = 1'b0;
        e_busy[c] = 1'b0; e_addr[c] = '0;
      end
    end
  endtask

  // phy driver: ack 1+ackd cycles after req rises, done doned cycles after ack,
  // plus stray done pulses whenever no accepted shift is outstanding
  task automatic phy_update();
    bit start_pending;
    if (reset_in) begin
      ph_pending = 1'b0; ph_req_since = -1;
      shift_ack_in = 1'b0; shift_done_in = 1'b0;
      return;
    end
    start_pending = ph_pending;
    shift_done_in = 1'b0;
    if (ph_pending && cyc == ph_done_at) begin
      shift_done_in = 1'b1; ph_pending = 1'b0;
    end else if (!start_pending && $urandom_range(0, 7) == 0) begin
      shift_done_in = 1'b1;
    end
    shift_ack_in = 1'b0;
    if (shift_req_out && !start_pending) begin
      if (ph_req_since < 0) ph_req_since = cyc;
      if (cyc >= ph_req_since + 1 + ackd[ph_k]) begin
        shift_ack_in = 1'b1; ph_pending = 1'b1;
        ph_done_at = cyc + doned[ph_k];
        ph_k++; ph_req_since = -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    reset_in  = (cyc < 5) || (cyc == rst_c);
    enable_in = (cyc < 5) || (cyc >= t_a && cyc < dis_c) || (cyc >= t_b && cyc < rst_c);
    phy_update();
    check_eq("outs", 32'({shift_req_out, latch_out, oe_n_out, frame_done_out, busy_out, row_addr_out}),
             32'({e_req[cyc], e_latch[cyc], e_oe[cyc], e_fd[cyc], e_busy[cyc], e_addr[cyc]}));
    if (e_req[cyc])
      check_eq("slot", 32'({shift_row_out, shift_plane_out}), 32'({e_row[cyc], e_plane[cyc]}));
    if (frame_done_out === 1'b1) fd_seen++;
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      e_addr[c] = '0; e_row[c] = '0; e_plane[c] = '0;
    end
    clear_from(0);
    for (int k = 0; k < NK; k++) begin
      ackd[k]  = (k < 8) ? 0 : $urandom_range(0, 2);
      doned[k] = (k < 8) ? 64 : $urandom_range(20, 220);
      lat_c[k] = 0;
    end
    rst_c = BIG; dis_c = BIG; t_b = BIG;

    // run a frame and a bit, then drop enable during display of slot (3,2) of frame 2
    t_a = 12;
    plan_run(t_a, 0, 80, BIG, BIG, te, ns);
    dis_c = lat_c[78] + 1 + $urandom_range(0, 63);
    clear_from(t_a + 1);
    plan_run(t_a, 0, 1000, dis_c, BIG, te, n_a);

    // restart from (0,0), then reset in the middle of a display
    t_b = te + 5 + $urandom_range(0, 10);
    plan_run(t_b, n_a, 6, BIG, BIG, te, ns);
    rst_c = lat_c[n_a + 2] + 1 + $urandom_range(0, 63);
    clear_from(t_b + 1);
    plan_run(t_b, n_a, 1000, BIG, rst_c, te, ns);
    t_fin = rst_c + 20;
    if (t_fin >= N) begin
      $display("FAIL plan_horizon got=%0d exp<%0d", t_fin, N);
      $fatal(1);
    end

    while (cyc < t_fin) step();

    check_eq("frame_done_count", 32'(fd_seen), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
